// File: rtl/max7219_frame_seq.sv
// Command sequencer feeding a MAX7219 serial driver: runs the init table, then resends dirty frame-buffer rows.
// Build option MAX7219_INTENSITY_PORT_EN adds a live intensity_in port that overrides INTENSITY.
`timescale 1ns/1ps

module max7219_frame_seq #(
    parameter logic [7:0]  INTENSITY    = 8'h08,
    parameter logic [7:0]  SCAN_LIMIT   = 8'h07,
    parameter logic [15:0] BUSY_TIMEOUT = 16'd1023
) (
    input  logic       sys_clk,
    input  logic       _rst,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    input  logic       busy,
`ifdef MAX7219_INTENSITY_PORT_EN
    input  logic [3:0] intensity_in,
`endif
    output logic       str,
    output logic [7:0] IRreg,
    output logic [7:0] data,
    output logic       init_done,
    output logic       seq_busy,
    output logic       timeout_err
);

    // state     | meaning
    // INIT_LD   | latch init table entry init_idx into IRreg/data
    // ISSUE     | str high for one cycle, arm busy timeout
    // WAIT_HI   | wait for driver busy to rise (or timeout)
    // WAIT_LO   | wait for driver busy to fall
    // IDLE      | nothing pending
    // ROW_LD    | latch lowest dirty row (or intensity update) into IRreg/data
    typedef enum logic [2:0] {
        S_INIT_LD,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_IDLE,
        S_ROW_LD
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  init_idx;
    logic [15:0] tmo_cnt;
    logic [7:0]  fb [8];
    logic [7:0]  dirty;
    logic        cmd_done, tmo_hit;

    logic [2:0]  row_sel;
    logic        row_any;
    logic        row_pending;
    logic [7:0]  row_ir, row_dat;
    logic        row_clr;
    logic [7:0]  init_addr, init_val;
    logic [7:0]  init_int;

`ifdef MAX7219_INTENSITY_PORT_EN
    logic [3:0] last_int;
    logic       int_dirty;

    assign init_int    = {4'h0, intensity_in};
    assign int_dirty   = init_done && (intensity_in != last_int);
    assign row_pending = row_any || int_dirty;

    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            last_int <= INTENSITY[3:0];
        end else if ((state == S_INIT_LD && init_idx == 3'd2) ||
                     (state == S_ROW_LD && int_dirty)) begin
            last_int <= intensity_in;
        end
    end
`else
    assign init_int    = INTENSITY;
    assign row_pending = row_any;
`endif

    // Scan from the top down so the lowest dirty index wins.
    always_comb begin
        row_sel = 3'd0;
        row_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (dirty[i]) begin
                row_sel = 3'(i);
                row_any = 1'b1;
            end
        end
    end

    always_comb begin
        row_ir  = {5'd0, row_sel} + 8'd1;
        row_dat = fb[row_sel];
        row_clr = 1'b1;
`ifdef MAX7219_INTENSITY_PORT_EN
        if (int_dirty) begin
            row_ir  = 8'h0A;
            row_dat = {4'h0, intensity_in};
            row_clr = 1'b0;
        end
`endif
    end

    always_comb begin
        init_addr = 8'h0C;
        init_val  = 8'h01;
        case (init_idx)
            3'd0:    begin init_addr = 8'h0F; init_val = 8'h00;       end
            3'd1:    begin init_addr = 8'h09; init_val = 8'h00;       end
            3'd2:    begin init_addr = 8'h0A; init_val = init_int;    end
            3'd3:    begin init_addr = 8'h0B; init_val = SCAN_LIMIT;  end
            default: begin init_addr = 8'h0C; init_val = 8'h01;       end
        endcase
    end

    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) state <= S_INIT_LD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        str      = 1'b0;
        cmd_done = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            S_INIT_LD: state_nx = S_ISSUE;
            S_ISSUE: begin
                str      = 1'b1;
                state_nx = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (busy) begin
                    state_nx = S_WAIT_LO;
                end else if (tmo_cnt == 16'd0) begin
                    tmo_hit  = 1'b1;
                    cmd_done = 1'b1;
                end
            end
            S_WAIT_LO: if (!busy) cmd_done = 1'b1;
            S_IDLE:    if (init_done && row_pending) state_nx = S_ROW_LD;
            S_ROW_LD:  state_nx = S_ISSUE;
            default:   state_nx = S_IDLE;
        endcase
        // An abandoned command finishes exactly like a completed one.
        if (cmd_done) begin
            state_nx = (!init_done && init_idx != 3'd4) ? S_INIT_LD : S_IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            init_idx    <= 3'd0;
            init_done   <= 1'b0;
            seq_busy    <= 1'b0;
            timeout_err <= 1'b0;
            tmo_cnt     <= 16'd0;
            IRreg       <= 8'h00;
            data        <= 8'h00;
            dirty       <= 8'hFF;
            for (int i = 0; i < 8; i++) fb[i] <= 8'h00;
        end else begin
            seq_busy <= (state_nx != S_IDLE);

            if (state == S_ISSUE) tmo_cnt <= BUSY_TIMEOUT;
            else if (state == S_WAIT_HI && tmo_cnt != 16'd0) tmo_cnt <= tmo_cnt - 16'd1;

            if (tmo_hit) timeout_err <= 1'b1;

            if (cmd_done && !init_done) begin
                if (init_idx == 3'd4) init_done <= 1'b1;
                else                  init_idx  <= init_idx + 3'd1;
            end

            if (state == S_INIT_LD) begin
                IRreg <= init_addr;
                data  <= init_val;
            end

            if (state == S_ROW_LD) begin
                IRreg <= row_ir;
                data  <= row_dat;
                if (row_clr) dirty[row_sel] <= 1'b0;
            end

            // Host writes and refresh come last so they override the row clear above.
            if (wr_en) begin
                fb[wr_row]    <= wr_data;
                dirty[wr_row] <= 1'b1;
            end
            if (refresh) dirty <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_max7219_frame_seq.sv
// Self-checking bench for max7219_frame_seq: behavioural MAX7219 driver model, directed row-write table
// and hand sequences for write/ROW_LD collision, busy timeout and mid-transfer reset.
`timescale 1ns/1ps

module tb_max7219_frame_seq;

    localparam logic [15:0] TMO = 16'd1023;

    typedef struct {
        logic [2:0] row;
        logic [7:0] val;
        logic [7:0] exp_ir;
        logic [7:0] exp_dat;
    } vec_t;

    logic       sys_clk = 1'b0;
    logic       _rst    = 1'b0;
    logic       wr_en   = 1'b0;
    logic [2:0] wr_row  = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       refresh = 1'b0;
    logic       busy    = 1'b0;
    logic       str, init_done, seq_busy, timeout_err;
    logic [7:0] IRreg, data;

    int   checks = 0;
    int   errors = 0;
    int   stab_err = 0;
    bit   drv_on = 1'b1;

    logic [7:0] q_ir[$];
    logic [7:0] q_dat[$];
    logic       q_idone[$];
    logic [7:0] model_fb [8];

    max7219_frame_seq dut (
        .sys_clk     (sys_clk),
        ._rst        (_rst),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .refresh     (refresh),
        .busy        (busy),
        .str         (str),
        .IRreg       (IRreg),
        .data        (data),
        .init_done   (init_done),
        .seq_busy    (seq_busy),
        .timeout_err (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Driver model: busy rises 2 cycles after str and stays high 34 cycles; reset aborts it.
    initial forever begin
        @(negedge sys_clk);
        if (str === 1'b1 && drv_on && _rst) begin
            @(negedge sys_clk);
            @(negedge sys_clk);
            if (_rst) begin
                busy = 1'b1;
                for (int i = 0; i < 34 && _rst; i++) @(negedge sys_clk);
                busy = 1'b0;
            end
        end
    end

    // Command log, plus a stability watch on IRreg/data while the driver is shifting.
    initial forever begin
        @(negedge sys_clk);
        if (str === 1'b1) begin
            q_ir.push_back(IRreg);
            q_dat.push_back(data);
            q_idone.push_back(init_done);
        end
        if (_rst && busy && q_ir.size() > 0 &&
            (IRreg !== q_ir[q_ir.size()-1] || data !== q_dat[q_dat.size()-1]))
            stab_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        q_ir.delete();
        q_dat.delete();
        q_idone.delete();
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 5 && n < 5000) begin
            @(negedge sys_clk);
            n++;
            if (!seq_busy) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 5) begin
            errors++;
            $display("FAIL %s: idle not reached, seq_busy=%0b expected 0", name, seq_busy);
        end
    endtask

    task automatic wait_str(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (str !== 1'b1 && n < budget);
        checks++;
        if (str !== 1'b1) begin
            errors++;
            $display("FAIL %s: no str within %0d cycles, str=%0b expected 1", name, budget, str);
        end
    endtask

    task automatic write_row(input logic [2:0] r, input logic [7:0] v);
        wr_en   = 1'b1;
        wr_row  = r;
        wr_data = v;
        model_fb[r] = v;
        @(negedge sys_clk);
        wr_en = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_str"},         {31'd0, str},         32'd0);
        chk({tag, "_IRreg"},       {24'd0, IRreg},       32'd0);
        chk({tag, "_data"},        {24'd0, data},        32'd0);
        chk({tag, "_init_done"},   {31'd0, init_done},   32'd0);
        chk({tag, "_seq_busy"},    {31'd0, seq_busy},    32'd0);
        chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    task automatic chk_cmd(input string name, input int idx, input logic [7:0] ir, input logic [7:0] dt);
        if (idx < q_ir.size()) begin
            chk({name, "_ir"},  {24'd0, q_ir[idx]},  {24'd0, ir});
            chk({name, "_dat"}, {24'd0, q_dat[idx]}, {24'd0, dt});
        end
    endtask

    initial begin
        vec_t vecs [4];
        logic [7:0] init_ir  [5];
        logic [7:0] init_dat [5];
        int   j;

        vecs[0] = '{row: 3'd3, val: 8'hE7, exp_ir: 8'h04, exp_dat: 8'hE7};
        vecs[1] = '{row: 3'd0, val: 8'h5A, exp_ir: 8'h01, exp_dat: 8'h5A};
        vecs[2] = '{row: 3'd7, val: 8'h81, exp_ir: 8'h08, exp_dat: 8'h81};
        vecs[3] = '{row: 3'd6, val: 8'hC3, exp_ir: 8'h07, exp_dat: 8'hC3};
        init_ir  = '{8'h0F, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        init_dat = '{8'h00, 8'h00, 8'h08, 8'h07, 8'h01};
        for (int i = 0; i < 8; i++) model_fb[i] = 8'h00;

        // Reset values, then the full power-up sequence.
        repeat (3) @(negedge sys_clk);
        chk_reset_outputs("reset");
        _rst = 1'b1;
        wait_idle("init_idle");
        chk("init_cmd_count", q_ir.size(), 32'd13);
        for (int i = 0; i < 13; i++) begin
            if (i < 5) chk_cmd($sformatf("init%0d", i), i, init_ir[i], init_dat[i]);
            else       chk_cmd($sformatf("row_boot%0d", i - 5), i, 8'(i - 4), 8'h00);
            if (i < q_idone.size())
                chk($sformatf("init_done_at_cmd%0d", i), {31'd0, q_idone[i]}, (i >= 5) ? 32'd1 : 32'd0);
        end
        chk("init_done_final", {31'd0, init_done}, 32'd1);
        chk("seq_busy_final", {31'd0, seq_busy}, 32'd0);

        // Single-row writes: exactly one command each.
        for (int k = 0; k < 4; k++) begin
            clear_log();
            write_row(vecs[k].row, vecs[k].val);
            wait_idle($sformatf("vec%0d_idle", k));
            chk($sformatf("vec%0d_count", k), q_ir.size(), 32'd1);
            chk_cmd($sformatf("vec%0d", k), 0, vecs[k].exp_ir, vecs[k].exp_dat);
        end

        // Row 7 written before row 0: lowest index still goes first.
        clear_log();
        write_row(3'd7, 8'hA5);
        write_row(3'd0, 8'h3C);
        wait_idle("burst_idle");
        chk("burst_count", q_ir.size(), 32'd2);
        chk_cmd("burst_first", 0, 8'h01, 8'h3C);
        chk_cmd("burst_second", 1, 8'h08, 8'hA5);

        // Write to row 2 lands in the very ROW_LD cycle that sends row 2.
        clear_log();
        wr_en = 1'b1; wr_row = 3'd2; wr_data = 8'hFF; model_fb[2] = 8'hFF;
        @(negedge sys_clk);
        wr_en = 1'b0;
        chk("race_idle_cycle", {31'd0, seq_busy}, 32'd0);
        @(negedge sys_clk);
        chk("race_row_ld_cycle", {31'd0, seq_busy}, 32'd1);
        wr_en = 1'b1; wr_row = 3'd2; wr_data = 8'h3C; model_fb[2] = 8'h3C;
        @(negedge sys_clk);
        wr_en = 1'b0;
        wait_idle("race_idle");
        chk("race_count", q_ir.size(), 32'd2);
        chk_cmd("race_first", 0, 8'h03, 8'hFF);
        chk_cmd("race_second", 1, 8'h03, 8'h3C);

        // Refresh together with a write: all rows resent, write included.
        clear_log();
        wr_en = 1'b1; wr_row = 3'd1; wr_data = 8'h11; model_fb[1] = 8'h11; refresh = 1'b1;
        @(negedge sys_clk);
        wr_en = 1'b0; refresh = 1'b0;
        wait_idle("refresh_idle");
        chk("refresh_count", q_ir.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            chk_cmd($sformatf("refresh_row%0d", i), i, 8'(i + 1), model_fb[i]);

        chk("data_stable_while_busy", stab_err, 32'd0);
        chk("no_timeout_yet", {31'd0, timeout_err}, 32'd0);

        // Reset while row 5 is shifting: async return to reset values, init restarts.
        clear_log();
        write_row(3'd5, 8'h99);
        j = 0;
        while (busy !== 1'b1 && j < 200) begin
            @(negedge sys_clk);
            j++;
        end
        chk("row5_busy_seen", {31'd0, busy}, 32'd1);
        chk_cmd("row5_cmd", 0, 8'h06, 8'h99);
        repeat (5) @(negedge sys_clk);
        #3 _rst = 1'b0;
        #1 chk_reset_outputs("midreset");
        repeat (3) @(negedge sys_clk);
        clear_log();
        for (int i = 0; i < 8; i++) model_fb[i] = 8'h00;
        _rst = 1'b1;
        wait_idle("reinit_idle");
        chk("reinit_count", q_ir.size(), 32'd13);
        chk_cmd("reinit_first", 0, 8'h0F, 8'h00);
        chk_cmd("reinit_row6", 10, 8'h06, 8'h00);

        // Driver never answers: timeout after BUSY_TIMEOUT, then next init entry.
        drv_on = 1'b0;
        _rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        _rst = 1'b1;
        wait_str("tmo_first_str", 20);
        chk("tmo_first_ir", {24'd0, IRreg}, 32'h0F);
        // WAIT_HI runs BUSY_TIMEOUT+1 cycles; the flag is visible one negedge later.
        j = 0;
        while (timeout_err !== 1'b1 && j < 1200) begin
            @(negedge sys_clk);
            j++;
        end
        chk("tmo_latency", j, 32'(TMO) + 32'd2);
        chk("tmo_err_set", {31'd0, timeout_err}, 32'd1);
        wait_str("tmo_next_str", 20);
        chk("tmo_next_ir", {24'd0, IRreg}, 32'h09);
        chk("tmo_next_dat", {24'd0, data}, 32'h00);
        chk("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
        chk("tmo_init_not_done", {31'd0, init_done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/max7219_frame_seq.md
Name: max7219_frame_seq

Overview:
- Command sequencer directly upstream of the MAX7219 serial driver; drives that driver's str/IRreg/data inputs and consumes its busy output.
- After reset, issues the MAX7219 init sequence, then keeps the 8 digit registers coherent with an internal 8x8 frame buffer written by the host.
- Only rows marked dirty are retransmitted, which minimises serial traffic.

Parameters:
- INTENSITY, 8'h08, value written to register 0x0A during init (0..15).
- SCAN_LIMIT, 8'h07, value written to register 0x0B during init.
- BUSY_TIMEOUT, 16'd1023, sys_clk cycles to wait for busy to rise after str before the command is abandoned.

Ports:
- sys_clk  in  1  system clock, rising edge.
- _rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  host frame-buffer write strobe.
- wr_row  in  3  row index 0..7; maps to digit register wr_row+1.
- wr_data  in  8  row pattern.
- refresh  in  1  single-cycle pulse; marks all 8 rows dirty.
- busy  in  1  from the driver; high while a frame is shifting.
- str  out  1  start pulse to the driver.
- IRreg  out  8  register address to the driver.
- data  out  8  register data to the driver.
- init_done  out  1  high once the init sequence has completed.
- seq_busy  out  1  high whenever the FSM is not in IDLE.
- timeout_err  out  1  sticky; set when busy fails to rise within BUSY_TIMEOUT.

Behaviour:
- Reset values: str=0, IRreg=8'h00, data=8'h00, init_done=0, seq_busy=0, timeout_err=0, frame buffer all 8'h00, all 8 dirty bits=1.
- Asserting reset mid-transfer aborts immediately to INIT index 0. The command in flight is not resumed.
- States:
  - INIT_LD: load the init entry at the current index.
  - ISSUE: str=1 for exactly one cycle.
  - WAIT_HI: wait for busy=1.
  - WAIT_LO: wait for busy=0.
  - IDLE.
  - ROW_LD: load the lowest-index dirty row.
- Init table, in order:
  - 0x0F<-0x00 (test off)
  - 0x09<-0x00 (no decode)
  - 0x0A<-INTENSITY
  - 0x0B<-SCAN_LIMIT
  - 0x0C<-0x01 (normal operation)
- init_done rises on the cycle WAIT_LO exits for the last init entry. Frame-buffer writes are accepted during init; rows are sent only after init_done.
- Handshake:
  - IRreg and data are registered in the LD state and held stable from ISSUE until WAIT_LO exits.
  - str is high only in ISSUE.
  - The next ISSUE occurs no earlier than 1 cycle after busy is seen low in WAIT_LO.
- WAIT_HI timeout:
  - A counter clears on entry to WAIT_HI.
  - If it reaches BUSY_TIMEOUT with busy still 0, timeout_err is set (sticky until reset) and the FSM advances as if the command completed.
  - busy already high on the ISSUE+1 cycle is valid.
- Row scan:
  - In IDLE with init_done=1 and any dirty bit set: go to ROW_LD, select the lowest dirty index r, latch IRreg=r+1 and data=fb[r], and clear dirty[r].
  - Priority is fixed low-to-high; no wrap-around fairness is needed because each pass clears the bits it sends.
- Simultaneous events:
  - wr_en to row r in the same cycle ROW_LD clears dirty[r]: the write wins. fb[r] is updated and dirty[r] stays 1, so the row is resent.
  - refresh concurrent with wr_en: all rows are dirty and the write is applied.
  - Writes to a row already latched do not alter the in-flight data.
- seq_busy = (state != IDLE).

Optional Feature:
- Macro: MAX7219_INTENSITY_PORT_EN.
- When defined:
  - Adds input intensity_in[3:0].
  - Init uses intensity_in, sampled in INIT_LD, instead of INTENSITY.
  - After init, any change of intensity_in versus the last-sent value sets an intensity-dirty flag.
  - This flag has priority over row dirty bits and issues 0x0A<-{4'h0,intensity_in}.
- When undefined: no port; intensity is fixed at INTENSITY; no extra FSM path.

Test Plan:
- Reset release with a behavioural driver model (busy high 34 cycles, 2 cycles after str) -> exactly 5 str pulses with (0x0F,00),(09,00),(0A,08),(0B,07),(0C,01), then 8 row commands IRreg=1..8, data=00; init_done high after the 5th; seq_busy low at the end.
- Idle, then write row 3 with 8'hE7 -> one command IRreg=4, data=E7; no other rows sent.
- Write rows 7 and 0 in the same burst -> IRreg=1 sent before IRreg=8.
- Write row 2 with 8'h3C in the exact ROW_LD cycle for row 2 (old value 8'hFF) -> two commands to IRreg=3: first FF, then 3C.
- Driver model never raises busy -> timeout_err=1 after BUSY_TIMEOUT cycles; the FSM proceeds to the next init entry.
- Assert _rst during WAIT_LO of the row-5 command -> outputs return to reset values asynchronously; after release, the init sequence restarts from 0x0F.
